// File: rtl/y86_de_pipe.sv
// y86_de_pipe: decode-to-execute pipeline stage for the Y86-64 core.
//
// The stage decodes register IDs from the D-stage fields and selects each
// operand, either from a later stage or from the register file. It also
// detects load-use hazards and mispredicted jumps, and holds the E-stage
// pipeline register, which can stall or insert a bubble.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   d_valid, d_icode, d_ifun   D-stage instruction valid and code fields
//   d_rA, d_rB, d_valC, d_valP D-stage register fields, constant, next PC
//   rf_valA, rf_valB           register file read data (addressed by d_srcA/B)
//   d_srcA, d_srcB             decoded source IDs (combinational)
//   e_dstE, e_valE, e_cnd      execute-stage destination, result, condition
//   m_dstE, m_dstM, m_valE, m_valM   M-stage destinations and values
//   w_dstE, w_dstM, w_valE, w_valM   W-stage destinations and values
//   stall_e                    downstream hold of the E register
//   E_*                        E-stage pipeline register contents
//   stall_d                    hold fetch PC and D register (combinational)
module y86_de_pipe #(
  parameter int unsigned      DATA_W = 64,
  parameter int unsigned      RID_W  = 4,
  parameter logic [RID_W-1:0] RNONE  = 4'hF,
  parameter logic [RID_W-1:0] RSP_ID = 4'h4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [RID_W-1:0]  d_rA,
  input  logic [RID_W-1:0]  d_rB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valP,
  input  logic [DATA_W-1:0] rf_valA,
  input  logic [DATA_W-1:0] rf_valB,
  output logic [RID_W-1:0]  d_srcA,
  output logic [RID_W-1:0]  d_srcB,
  input  logic [RID_W-1:0]  e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic              e_cnd,
  input  logic [RID_W-1:0]  m_dstE,
  input  logic [RID_W-1:0]  m_dstM,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [RID_W-1:0]  w_dstE,
  input  logic [RID_W-1:0]  w_dstM,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [DATA_W-1:0] w_valM,
  input  logic              stall_e,
  output logic              E_valid,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [RID_W-1:0]  E_dstE,
  output logic [RID_W-1:0]  E_dstM,
  output logic [RID_W-1:0]  E_srcA,
  output logic [RID_W-1:0]  E_srcB,
  output logic              stall_d
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  logic [RID_W-1:0]  d_dstE, d_dstM;
  logic [DATA_W-1:0] sel_valA, sel_valB;
  logic              lu, mp;

  // Register ID decode; an invalid D slot decodes to no registers at all.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    if (d_valid) begin
      case (d_icode)
        I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = d_rA;
        I_RET, I_POPQ:                      d_srcA = RSP_ID;
        default:                            d_srcA = RNONE;
      endcase
      case (d_icode)
        I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = d_rB;
        I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RSP_ID;
        default:                            d_srcB = RNONE;
      endcase
      case (d_icode)
        I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = d_rB;
        I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = RSP_ID;
        default:                            d_dstE = RNONE;
      endcase
      case (d_icode)
        I_MRMOVQ, I_POPQ:                   d_dstM = d_rA;
        default:                            d_dstM = RNONE;
      endcase
    end
  end

  // Forwarding takes the youngest producer first. jXX and call carry valP in
  // the valA slot, so they bypass the chain entirely.
  always_comb begin
    sel_valA = rf_valA;
    if (d_icode == I_JXX || d_icode == I_CALL)  sel_valA = d_valP;
    else if (d_srcA != RNONE) begin
      if      (d_srcA == e_dstE) sel_valA = e_valE;
      else if (d_srcA == m_dstM) sel_valA = m_valM;
      else if (d_srcA == m_dstE) sel_valA = m_valE;
      else if (d_srcA == w_dstM) sel_valA = w_valM;
      else if (d_srcA == w_dstE) sel_valA = w_valE;
    end
  end

  always_comb begin
    sel_valB = rf_valB;
    if (d_srcB != RNONE) begin
      if      (d_srcB == e_dstE) sel_valB = e_valE;
      else if (d_srcB == m_dstM) sel_valB = m_valM;
      else if (d_srcB == m_dstE) sel_valB = m_valE;
      else if (d_srcB == w_dstM) sel_valB = w_valM;
      else if (d_srcB == w_dstE) sel_valB = w_valE;
    end
  end

  // A load in E whose destination is needed by D must wait one cycle.
  assign lu = E_valid && (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
              (E_dstM != RNONE) && (E_dstM == d_srcA || E_dstM == d_srcB);
  assign mp = E_valid && (E_icode == I_JXX) && !e_cnd;
  assign stall_d = lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_valid <= 1'b0;
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (stall_e) begin
      // Downstream hold: keep every field.
    end else if (lu || mp) begin
      E_valid <= 1'b0;
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_valid <= d_valid;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= sel_valA;
      E_valB  <= sel_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_y86_de_pipe.sv
// Self-checking bench for y86_de_pipe: directed scenarios plus randomized
// traffic compared against a table-driven reference model of the E register.
module tb_y86_de_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
  logic [63:0] d_valC, d_valP, rf_valA, rf_valB;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  e_dstE, m_dstE, m_dstM, w_dstE, w_dstM;
  logic [63:0] e_valE, m_valE, m_valM, w_valE, w_valM;
  logic        e_cnd, stall_e;
  logic        E_valid;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        stall_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  y86_de_pipe #(.DATA_W(64), .RID_W(4), .RNONE(4'hF), .RSP_ID(4'h4)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP),
    .rf_valA(rf_valA), .rf_valB(rf_valB), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_dstE(e_dstE), .e_valE(e_valE), .e_cnd(e_cnd),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .m_valE(m_valE), .m_valM(m_valM),
    .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
    .stall_e(stall_e), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .stall_d(stall_d)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [3:0]  ic, fn;
    logic [63:0] c, a, b;
    logic [3:0]  de, dm, sa, sb;
  } e_t;

  localparam e_t BUBBLE = '{v: 1'b0, ic: 4'h1, fn: 4'h0, c: 64'h0, a: 64'h0, b: 64'h0,
                            de: 4'hF, dm: 4'hF, sa: 4'hF, sb: 4'hF};

  // One bit per icode: which icodes take the field / which take %rsp.
  localparam logic [15:0] SA_RA = 16'h0454, SA_SP = 16'h0A00;
  localparam logic [15:0] SB_RB = 16'h0070, SB_SP = 16'h0F00;
  localparam logic [15:0] DE_RB = 16'h004C, DE_SP = 16'h0F00;
  localparam logic [15:0] DM_RA = 16'h0820, DM_SP = 16'h0000;

  e_t m;

  function automatic logic [3:0] pick(input logic [15:0] take_fld, input logic [15:0] take_sp,
                                      input logic [3:0] fld);
    if (!d_valid) return 4'hF;
    if (take_fld[d_icode]) return fld;
    if (take_sp[d_icode]) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf);
    logic [3:0]  ids[5];
    logic [63:0] vals[5];
    ids  = '{e_dstE, m_dstM, m_dstE, w_dstM, w_dstE};
    vals = '{e_valE, m_valM, m_valE, w_valM, w_valE};
    if (src == 4'hF) return rf;
    for (int i = 0; i < 5; i++) if (ids[i] == src) return vals[i];
    return rf;
  endfunction

  function automatic logic model_lu();
    logic [3:0] a, b;
    a = pick(SA_RA, SA_SP, d_rA);
    b = pick(SB_RB, SB_SP, d_rB);
    return m.v && (m.ic == 4'h5 || m.ic == 4'hB) && m.dm != 4'hF && (m.dm == a || m.dm == b);
  endfunction

  function automatic e_t model_next();
    e_t n;
    if (stall_e) return m;
    if (model_lu() || (m.v && m.ic == 4'h7 && !e_cnd)) return BUBBLE;
    n.v  = d_valid;
    n.ic = d_icode;
    n.fn = d_ifun;
    n.c  = d_valC;
    n.sa = pick(SA_RA, SA_SP, d_rA);
    n.sb = pick(SB_RB, SB_SP, d_rB);
    n.de = pick(DE_RB, DE_SP, d_rB);
    n.dm = pick(DM_RA, DM_SP, d_rA);
    n.a  = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valP : fwd(n.sa, rf_valA);
    n.b  = fwd(n.sb, rf_valB);
    return n;
  endfunction

  // Advance one clock: model computed from inputs held stable across the edge.
  task automatic step();
    @(posedge clk);
    m = model_next();
    #1;
  endtask

  task automatic idle();
    d_valid = 1'b0; d_icode = 4'h1; d_ifun = 4'h0; d_rA = 4'hF; d_rB = 4'hF;
    d_valC = '0; d_valP = '0; rf_valA = '0; rf_valB = '0;
    e_dstE = 4'hF; m_dstE = 4'hF; m_dstM = 4'hF; w_dstE = 4'hF; w_dstM = 4'hF;
    e_valE = '0; m_valE = '0; m_valM = '0; w_valE = '0; w_valM = '0;
    e_cnd = 1'b1; stall_e = 1'b0;
  endtask

  task automatic load_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    d_valid = 1'b1; d_icode = ic; d_ifun = 4'h0; d_rA = ra; d_rB = rb;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    m = BUBBLE;
    repeat (2) @(negedge clk);
    tests++; if ({E_valid, E_icode, E_ifun} !== 9'h010) begin fails++;
      $display("FAIL reset_codes: got v/ic/fn %h expected 010", {E_valid, E_icode, E_ifun}); end
    tests++; if ({E_dstE, E_dstM, E_srcA, E_srcB} !== 16'hFFFF) begin fails++;
      $display("FAIL reset_ids: got %h expected ffff", {E_dstE, E_dstM, E_srcA, E_srcB}); end
    tests++; if ({E_valC, E_valA, E_valB} !== 192'h0) begin fails++;
      $display("FAIL reset_vals: got %h expected 0", {E_valC, E_valA, E_valB}); end
    rst_n = 1'b1;
    // Load E_valA=0x55, then reset in the middle of the next cycle.
    load_d(4'h2, 4'h1, 4'h7); rf_valA = 64'h55;
    step();
    tests++; if (E_valA !== 64'h55) begin fails++;
      $display("FAIL reset_preload: E_valA=%h expected 55", E_valA); end
    load_d(4'h6, 4'h3, 4'h3); rf_valA = 64'h77;
    #2 rst_n = 1'b0;
    m = BUBBLE;
    #1;
    tests++; if (E_icode !== 4'h1 || E_valid !== 1'b0 || E_valA !== 64'h0 || E_dstE !== 4'hF) begin
      fails++;
      $display("FAIL reset_async: ic=%h v=%b valA=%h dstE=%h expected 1 0 0 f",
               E_icode, E_valid, E_valA, E_dstE); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_forward_priority();
    idle();
    load_d(4'h6, 4'h3, 4'h7); rf_valA = 64'hAA; rf_valB = 64'h77;
    e_dstE = 4'h3; e_valE = 64'h10;
    m_dstE = 4'h3; m_valE = 64'h20;
    w_dstE = 4'h3; w_valE = 64'h30;
    step();
    tests++; if (E_valA !== 64'h10) begin fails++;
      $display("FAIL fwd_e: E_valA=%h expected 10", E_valA); end
    tests++; if (E_valB !== 64'h77 || E_icode !== 4'h6) begin fails++;
      $display("FAIL fwd_rfB: E_valB=%h ic=%h expected 77 6", E_valB, E_icode); end
    e_dstE = 4'hF;
    step();
    tests++; if (E_valA !== 64'h20) begin fails++;
      $display("FAIL fwd_m: E_valA=%h expected 20", E_valA); end
    m_dstE = 4'hF;
    w_dstM = 4'h3; w_valM = 64'h40;
    step();
    tests++; if (E_valA !== 64'h40) begin fails++;
      $display("FAIL fwd_wM: E_valA=%h expected 40", E_valA); end
  endtask

  task automatic test_load_use();
    idle();
    load_d(4'h5, 4'h2, 4'h1); rf_valB = 64'h1000;
    step();
    tests++; if (E_dstM !== 4'h2 || E_icode !== 4'h5) begin fails++;
      $display("FAIL lu_load: E_dstM=%h ic=%h expected 2 5", E_dstM, E_icode); end
    load_d(4'h6, 4'h2, 4'h5);
    #1;
    tests++; if (stall_d !== 1'b1) begin fails++;
      $display("FAIL lu_stall: stall_d=%b expected 1", stall_d); end
    step();
    tests++; if (E_valid !== 1'b0 || E_icode !== 4'h1 || E_dstE !== 4'hF) begin fails++;
      $display("FAIL lu_bubble: v=%b ic=%h dstE=%h expected 0 1 f", E_valid, E_icode, E_dstE); end
    m_dstM = 4'h2; m_valM = 64'h99;
    #1;
    tests++; if (stall_d !== 1'b0) begin fails++;
      $display("FAIL lu_release: stall_d=%b expected 0", stall_d); end
    step();
    tests++; if (E_valA !== 64'h99 || E_valid !== 1'b1 || E_icode !== 4'h6) begin fails++;
      $display("FAIL lu_fwd: valA=%h v=%b ic=%h expected 99 1 6", E_valA, E_valid, E_icode); end
  endtask

  task automatic test_call_push();
    idle();
    load_d(4'h8, 4'hF, 4'hF); d_valP = 64'h100; rf_valB = 64'h800; d_valC = 64'h4000;
    step();
    tests++; if (E_valA !== 64'h100 || E_valB !== 64'h800) begin fails++;
      $display("FAIL call_vals: valA=%h valB=%h expected 100 800", E_valA, E_valB); end
    tests++; if (E_srcB !== 4'h4 || E_dstE !== 4'h4 || E_srcA !== 4'hF) begin fails++;
      $display("FAIL call_ids: srcB=%h dstE=%h srcA=%h expected 4 4 f", E_srcB, E_dstE, E_srcA); end
    load_d(4'hA, 4'h6, 4'hF); rf_valA = 64'h66;
    step();
    tests++; if (E_srcA !== 4'h6 || E_srcB !== 4'h4 || E_valA !== 64'h66) begin fails++;
      $display("FAIL push_ids: srcA=%h srcB=%h valA=%h expected 6 4 66", E_srcA, E_srcB, E_valA); end
  endtask

  task automatic test_mispredict();
    idle();
    load_d(4'h7, 4'hF, 4'hF); d_valC = 64'h2000; d_valP = 64'h1009;
    step();
    tests++; if (E_icode !== 4'h7 || E_valid !== 1'b1) begin fails++;
      $display("FAIL mp_load: ic=%h v=%b expected 7 1", E_icode, E_valid); end
    load_d(4'h6, 4'h1, 4'h2); e_cnd = 1'b0;
    step();
    tests++; if (E_valid !== 1'b0 || E_icode !== 4'h1 || E_valC !== 64'h0) begin fails++;
      $display("FAIL mp_bubble: v=%b ic=%h valC=%h expected 0 1 0", E_valid, E_icode, E_valC); end
    load_d(4'h7, 4'hF, 4'hF); e_cnd = 1'b1;
    step();
    load_d(4'h6, 4'h1, 4'h2); e_cnd = 1'b0; stall_e = 1'b1;
    step();
    tests++; if (E_icode !== 4'h7 || E_valid !== 1'b1 || E_valC !== 64'h2000 || E_valA !== 64'h1009) begin
      fails++;
      $display("FAIL mp_hold: ic=%h v=%b valC=%h valA=%h expected 7 1 2000 1009",
               E_icode, E_valid, E_valC, E_valA); end
    stall_e = 1'b0;
    step();
    tests++; if (E_valid !== 1'b0 || E_icode !== 4'h1) begin fails++;
      $display("FAIL mp_after_hold: v=%b ic=%h expected 0 1", E_valid, E_icode); end
  endtask

  task automatic test_rnone_guard();
    idle();
    load_d(4'h5, 4'hF, 4'h1);          // load with no destination register
    step();
    load_d(4'h3, 4'hF, 4'h3); d_valC = 64'h5; rf_valA = 64'h1234;
    w_dstE = 4'hF; w_valE = 64'hAB;
    #1;
    tests++; if (stall_d !== 1'b0) begin fails++;
      $display("FAIL rnone_stall: stall_d=%b expected 0", stall_d); end
    step();
    tests++; if (E_valA !== 64'h1234 || E_srcA !== 4'hF || E_dstE !== 4'h3 || E_valC !== 64'h5) begin
      fails++;
      $display("FAIL rnone_fwd: valA=%h srcA=%h dstE=%h valC=%h expected 1234 f 3 5",
               E_valA, E_srcA, E_dstE, E_valC); end
  endtask

  // ---------------- randomized traffic ----------------
  function automatic logic [3:0] rid();
    int unsigned r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'hF : 4'(r);
  endfunction

  task automatic test_random();
    e_t got;
    logic [3:0] exp_a, exp_b;
    logic       exp_stall;
    idle();
    for (int n = 0; n < 400; n++) begin
      d_valid = ($urandom_range(0, 99) < 85);
      d_icode = 4'($urandom_range(0, 15));
      d_ifun  = 4'($urandom);
      d_rA = rid(); d_rB = rid();
      d_valC = {$urandom, $urandom}; d_valP = {$urandom, $urandom};
      rf_valA = {$urandom, $urandom}; rf_valB = {$urandom, $urandom};
      e_dstE = rid(); m_dstE = rid(); m_dstM = rid(); w_dstE = rid(); w_dstM = rid();
      e_valE = {$urandom, $urandom}; m_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      w_valE = {$urandom, $urandom}; w_valM = {$urandom, $urandom};
      e_cnd = 1'($urandom);
      stall_e = ($urandom_range(0, 99) < 15);
      #1;
      exp_a = pick(SA_RA, SA_SP, d_rA);
      exp_b = pick(SB_RB, SB_SP, d_rB);
      exp_stall = model_lu();
      tests++; if ({d_srcA, d_srcB, stall_d} !== {exp_a, exp_b, exp_stall}) begin fails++;
        $display("FAIL rand_comb[%0d]: srcA/srcB/stall=%h/%h/%b expected %h/%h/%b",
                 n, d_srcA, d_srcB, stall_d, exp_a, exp_b, exp_stall); end
      step();
      got = {E_valid, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
      tests++; if (got !== m) begin fails++;
        $display("FAIL rand_E[%0d]: got %h expected %h", n, got, m); end
    end
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_load_use();
    test_call_push();
    test_mispredict();
    test_rnone_guard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/y86_de_pipe.md
Name: y86_de_pipe

Overview:
- Pipelined decode-to-execute stage for the Y86-64 core; successor to the single-cycle decode/execute/mem/writeback harness.
- Derives source and destination register IDs from icode/rA/rB.
- Selects forwarded operands from the E/M/W stages, detects load-use hazards, and holds the E-stage pipeline register with stall and bubble control.
- Sits between fetch/D register and the execute unit.

Parameters:
DATA_W, 64, operand/data width in bits
RID_W, 4, register ID width
RNONE, 4'hF, "no register" ID; never matches in forwarding or hazard compares
RSP_ID, 4'h4, stack pointer register ID

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  D-stage instruction valid
d_icode  in  4  D-stage icode
d_ifun  in  4  D-stage ifun
d_rA  in  RID_W  rA field
d_rB  in  RID_W  rB field
d_valC  in  DATA_W  constant
d_valP  in  DATA_W  next PC
rf_valA  in  DATA_W  register file read, port A (combinational, addressed by d_srcA)
rf_valB  in  DATA_W  register file read, port B (addressed by d_srcB)
d_srcA  out  RID_W  decoded source A (combinational)
d_srcB  out  RID_W  decoded source B (combinational)
e_dstE  in  RID_W  execute-stage effective dstE (after cmov cnd)
e_valE  in  DATA_W  execute ALU result this cycle
e_cnd  in  1  execute condition result
m_dstE, m_dstM  in  RID_W  M-stage destinations
m_valE, m_valM  in  DATA_W  M-stage ALU result / memory read data
w_dstE, w_dstM  in  RID_W  W-stage destinations
w_valE, w_valM  in  DATA_W  W-stage values
stall_e  in  1  downstream hold; E register keeps contents
E_valid  out  1  E register valid
E_icode, E_ifun  out  4  E register code fields
E_valC, E_valA, E_valB  out  DATA_W  E register operands
E_dstE, E_dstM, E_srcA, E_srcB  out  RID_W  E register IDs
stall_d  out  1  hold fetch PC and D register (combinational)

Behaviour:
- Reset (async on rst_n low; released synchronously):
  - E_valid=0, E_icode=4'h1 (nop), E_ifun=0.
  - E_valC/E_valA/E_valB=0.
  - All E_ IDs=RNONE.
  - Reset mid-operation discards the in-flight instruction with no partial update.
- Decode, combinational; RNONE where not listed:
  - srcA = rA for icode 2,4,6,A; RSP_ID for 9,B.
  - srcB = rB for 4,5,6; RSP_ID for 8,9,A,B.
  - dstE = rB for 2,3,6; RSP_ID for 8,9,A,B.
  - dstM = rA for 5,B.
  - d_valid=0 forces all four IDs to RNONE.
- Operand select, valA:
  - icode 7 or 8: valA = d_valP.
  - Otherwise first match in order: e_dstE→e_valE, m_dstM→m_valM, m_dstE→m_valE, w_dstM→w_valM, w_dstE→w_valE, else rf_valA.
- Operand select, valB: same priority chain on srcB with rf_valB fallback; no valP case.
- Forwarding compares are skipped when the src ID is RNONE.
- Load-use hazard:
  - lu = E_valid & (E_icode==5 | E_icode==B) & E_dstM!=RNONE & (E_dstM==d_srcA | E_dstM==d_srcB).
  - stall_d = lu.
- Mispredict: mp = E_valid & E_icode==7 & !e_cnd.
- E register update priority per clock:
  1. stall_e=1: hold all fields. stall_d is still driven from current values.
  2. lu or mp: bubble, i.e. the reset values (nop, E_valid=0, RNONE IDs).
  3. Else load decoded D fields and selected operands; E_valid=d_valid.
- Simultaneous lu and mp: bubble; stall_d=lu as defined. Fetch control resolves the mispredict.
- Latency: 1 cycle, D to E.
- Widths:
  - All operand paths are DATA_W with no sign or zero extension.
  - icode/ifun are fixed at 4 bits regardless of parameters.

Test Plan:
- Reset: rst_n=0 mid-stream with E_valA=0x55 -> E_icode=1, E_valid=0, E_valA=0, E_dstE=F immediately, before the next clk edge.
- Forwarding priority: OPq rA=3 with e_dstE=3/e_valE=0x10, m_dstE=3/m_valE=0x20, w_dstE=3/w_valE=0x30 -> E_valA=0x10 next cycle. With e_dstE=F -> E_valA=0x20.
- Load-use: E holds mrmovq with E_dstM=2; D presents addq rA=2, rB=5 -> stall_d=1 that cycle and E becomes a bubble. Next cycle, with m_dstM=2/m_valM=0x99 -> E_valA=0x99, stall_d=0.
- Call/push decode: call (icode 8, valP=0x100), rf_valB=0x800 -> E_valA=0x100, E_valB=0x800, E_srcB=4, E_dstE=4. pushq rA=6 -> E_srcA=6, E_srcB=4.
- Mispredict with stall_e: E_icode=7 and e_cnd=0 -> E bubble next edge. Repeat with stall_e=1 -> E_icode stays 7, contents unchanged.
- RNONE guard: irmovq (srcA=F) with w_dstE=F and w_valE=0xAB -> E_valA=rf_valA, no forward; stall_d=0.
